// File: rtl/tlc_pkg.sv
// Shared traffic-light-controller definitions: interval addresses, default intervals, light codes.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package tlc_pkg;

  // Interval register addresses; address 3 is reserved and reads as BASE.
  localparam logic [1:0] BASE_ADD = 2'd0;
  localparam logic [1:0] EXT_ADD  = 2'd1;
  localparam logic [1:0] YEL_ADD  = 2'd2;

  // Power-on interval lengths in seconds.
  localparam int DEF_BASE_SEC = 6;
  localparam int DEF_EXT_SEC  = 3;
  localparam int DEF_YEL_SEC  = 2;

  // Light code shared with the light FSM.
  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2,
    LIGHT_OFF    = 2'd3
  } light_t;

  // Map an interval address onto a real entry; the reserved code falls back to BASE.
  function automatic logic [1:0] entry_of(input logic [1:0] addr);
    return (addr == 2'd3) ? BASE_ADD : addr;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler producing a one-second tick from the system clock while enabled.
// Latency: tick is combinational from the prescaler register, asserted on the wrap cycle.
// Backpressure: none; clear restarts the second from zero and suppresses the tick that cycle.
module tick_divider #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic sys_reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;

  assign tick = enable && !clear && (presc == LAST);

  // Prescaler: cleared on (re)start or abort, otherwise counts 0..LAST while enabled.
  always_ff @(posedge clk) begin
    if (!sys_reset_n) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (enable) begin
      presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer: counts the selected interval in seconds and pulses expired at the end.
// Latency: expired is high in the cycle after edge start+N*TICKS_PER_SEC; all outputs registered.
// Backpressure: none; start and programming strobes are accepted every cycle, programming aborts the count.
module interval_timer
  import tlc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int CNT_W         = 4,
  parameter int DEF_BASE      = DEF_BASE_SEC,
  parameter int DEF_EXT       = DEF_EXT_SEC,
  parameter int DEF_YEL       = DEF_YEL_SEC
) (
  input  logic             clk,
  input  logic             sys_reset_n,
  input  logic             start_timer,
  input  logic [1:0]       interval_address,
  input  logic             prg_sync_in,
  input  logic [1:0]       prg_sel,
  input  logic [CNT_W-1:0] prg_value,
  output logic             expired,
  output logic             one_hz_enable,
  output logic [CNT_W-1:0] time_left
);

  logic [CNT_W-1:0] base_q, ext_q, yel_q;
  logic [CNT_W-1:0] start_value;
  logic [CNT_W-1:0] prg_clamped;
  logic [CNT_W-1:0] count;
  logic             running;
  logic             tick;

  // A strobe either restarts or aborts the count, so the second restarts from zero in both cases.
  tick_divider #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_divider (
    .clk        (clk),
    .sys_reset_n(sys_reset_n),
    .clear      (start_timer | prg_sync_in),
    .enable     (running),
    .tick       (tick)
  );

  assign prg_clamped = (prg_value == '0) ? CNT_W'(1) : prg_value;
  assign time_left   = count;

  // Interval lookup for a start; the reserved address reads BASE.
  always_comb begin
    start_value = base_q;
    case (entry_of(interval_address))
      EXT_ADD: start_value = ext_q;
      YEL_ADD: start_value = yel_q;
      default: start_value = base_q;
    endcase
  end

  // Interval register file: defaults on reset, clamped writes from the programming strobe.
  always_ff @(posedge clk) begin
    if (!sys_reset_n) begin
      base_q <= CNT_W'(DEF_BASE);
      ext_q  <= CNT_W'(DEF_EXT);
      yel_q  <= CNT_W'(DEF_YEL);
    end else if (prg_sync_in) begin
      case (prg_sel)
        BASE_ADD: base_q <= prg_clamped;
        EXT_ADD:  ext_q  <= prg_clamped;
        YEL_ADD:  yel_q  <= prg_clamped;
        default:  ;
      endcase
    end
  end

  // Down-counter with priority programming abort > start > tick; expiry on the tick that leaves zero.
  always_ff @(posedge clk) begin
    if (!sys_reset_n) begin
      count         <= '0;
      running       <= 1'b0;
      expired       <= 1'b0;
      one_hz_enable <= 1'b0;
    end else begin
      expired       <= 1'b0;
      one_hz_enable <= tick;
      if (prg_sync_in) begin
        count   <= '0;
        running <= 1'b0;
      end else if (start_timer) begin
        count   <= start_value;
        running <= 1'b1;
      end else if (tick) begin
        count <= count - 1'b1;
        if (count == CNT_W'(1)) begin
          running <= 1'b0;
          expired <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/interval_timer.md
# interval_timer

Programmable interval timer that serves the traffic-light controller's timer handshake. It holds the three interval lengths (base, extended, yellow) and answers each `start_timer` request by counting the selected interval in seconds. When the interval elapses it returns a one-cycle `expired` pulse. It sits between the light FSM and the programming/sync front end, and owns the 1 Hz time base.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: clocks per one-second tick; use 4 for simulation.
- `CNT_W`, default 4: width of interval values and the down-counter.
- `DEF_BASE`, default 6: reset value of the base interval, in seconds.
- `DEF_EXT`, default 3: reset value of the extended interval, in seconds.
- `DEF_YEL`, default 2: reset value of the yellow interval, in seconds.

- `clk`  in  1  system clock.
- `sys_reset_n`  in  1  synchronous, active-low reset.
- `start_timer`  in  1  load the selected interval and (re)start counting.
- `interval_address`  in  2  interval select: 0 = BASE, 1 = EXT, 2 = YEL, 3 = reserved.
- `prg_sync_in`  in  1  synchronized programming strobe.
- `prg_sel`  in  2  interval register to write; same encoding as `interval_address`.
- `prg_value`  in  CNT_W  new interval value, in seconds.
- `expired`  out  1  one-cycle pulse when the running interval ends.
- `one_hz_enable`  out  1  one-cycle tick pulse, for observation only.
- `time_left`  out  CNT_W  current down-counter value.

## Operation
- Interval register file: three entries of CNT_W bits.
  - Reset loads DEF_BASE, DEF_EXT and DEF_YEL.
- Programming:
  - `prg_sync_in`=1 writes `prg_value` into entry `prg_sel`.
  - `prg_sel`=3: the write is ignored.
  - `prg_value`=0 is stored as 1, so every interval is at least one second.
- `prg_sync_in` also aborts any running count: running←0, count←0, no `expired` pulse. This matches the controller, which reprograms and then restarts.
- Start:
  - `start_timer`=1 loads count←entry[`interval_address`], sets running←1 and clears the prescaler to 0.
  - Address 3 loads the BASE entry.
  - A start while running restarts the count; the old interval never expires.
- Counting:
  - The prescaler counts 0..TICKS_PER_SEC-1 only while running; the tick fires at the wrap.
  - Each tick decrements count.
  - A tick with count==1 sets count←0, running←0 and `expired`←1 for exactly one cycle.
- Idle (running=0): count holds, no ticks, `expired`=0.
- Priority within a cycle, highest first:
  1. reset
  2. `prg_sync_in`
  3. `start_timer`
  4. tick
- If `prg_sync_in` and `start_timer` arrive in the same cycle: the write happens, the abort wins, and the start is dropped.

## Timing
- All outputs are registered.
- Reset values: `expired`=0, `one_hz_enable`=0, `time_left`=0, running=0, prescaler=0.
- `start_timer` sampled at edge E0 with value N: `expired` is high during the cycle after edge E0+N·TICKS_PER_SEC.
- `expired` is never high for two consecutive cycles. The controller advances state on every cycle it sees `expired`.
- The controller answers `expired` with `start_timer` one cycle later. During that gap the timer is idle, so no extra pulse can occur.
- A write takes effect for any start sampled on a later edge. It has no effect on a count already loaded, and that count is aborted by the same strobe anyway.
- `time_left` updates on the same edge as the load or decrement.
- Reset in mid-count aborts silently and restores the default intervals.

## Structure
- Shared package `tlc_pkg` holds:
  - interval address constants BASE_ADD=0, EXT_ADD=1, YEL_ADD=2;
  - default interval constants;
  - a light-code typedef, which the FSM shares.
- Sub-module `tick_divider`: prescaler with `clear` and `enable` inputs and a `tick` output. `one_hz_enable` is driven from it.
- The top level holds the register file, the down-counter and the `expired` logic.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset, then `start_timer` with addr 0: `expired` pulses once, 24 cycles after the start edge; `time_left` steps 6→5→…→0.
- Program EXT=9 (`prg_sync_in`, `prg_sel`=1), then start with addr 1: `expired` at 36 cycles; a following YEL start still gives 8 cycles.
- Program YEL with `prg_value`=0, then start with addr 2: entry reads 1 and `expired` comes at 4 cycles. Start with addr 3: 24 cycles (base).
- Start with addr 0, then restart with addr 2 at cycle 10: exactly one `expired`, 8 cycles after the restart.
- Start with addr 0, then at cycle 12 pulse `prg_sync_in` together with `start_timer`: no `expired` ever; `time_left`=0 and the write is applied.
- Start with addr 1, then drive `sys_reset_n`=0 at cycle 5: all outputs go to 0 next edge, entries return to 6/3/2, and no `expired` follows.
